fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
// - Instruction-supply end of the 9-bit machine-code path. Owns the program counter and
//   drives the sync instruction ROM, then presents {Instruction, InstrValid} to the
//   combinational decoder.
// - Consumes the decoder's Jump/Ack results and runs the Start/Done program handshake
//   with the testbench.
// PARAMETERS
// - PC_W    10  program counter / ROM address width; program space 2**PC_W words
// - INSTR_W 9   machine-code width; must equal defs_pkg::kINSTR_W
// - OFF_W   8   signed relative jump offset width, OFF_W <= PC_W
// - CNT_W   32  perf counter width (only with FETCH_PERF_EN)
// PORTS
// - Clk         in   1        clock, all state on rising edge
// - Reset       in   1        asynchronous, active-high
// - Start       in   1        level; begin program from address 0
// - Stall       in   1        hold current instruction and PC
// - Jump        in   1        decoder: take relative jump this cycle
// - JumpOff     in   OFF_W    signed offset applied to current PC
// - AckIn       in   1        decoder: current instruction is the halt word
// - RomData     in   INSTR_W  ROM read data (1-cycle latency after RomAddr)
// - RomAddr     out  PC_W     ROM read address (combinational next-PC)
// - Instruction out  INSTR_W  machine code to decoder; kNOP when not valid
// - InstrValid  out  1        Instruction is live and must be executed
// - ProgCtr     out  PC_W     address of the presented Instruction
// - Done        out  1        program halted; held until next Start
// - CycleCount  out  CNT_W    RUN cycles (FETCH_PERF_EN); else tied 0
// - InstrCount  out  CNT_W    retired instructions (FETCH_PERF_EN); else tied 0
// BEHAVIOUR
// - Reset: state=IDLE, ProgCtr=0, RomAddr=0, Instruction=kNOP, InstrValid=0, Done=0.
//   Counters=0. Reset mid-RUN aborts immediately; no partial instruction survives.
// - FSM IDLE -> PRIME -> RUN -> HALT -> PRIME ...
//   - IDLE:  RomAddr=0. Start=1 -> PRIME.
//   - PRIME: one cycle; ROM reads addr 0. ProgCtr<=0; -> RUN.
//     InstrValid first asserts in the first RUN cycle (Start-to-valid latency 2 cycles).
//   - RUN:   Instruction=RomData, InstrValid=1. The next PC is chosen in priority order:
//     1. AckIn=1 -> HALT; PC frozen; AckIn beats Stall and Jump.
//     2. Stall=1 -> PC held; RomAddr=ProgCtr, so the same word is re-read.
//     3. Jump=1 -> PC = ProgCtr + sign_ext(JumpOff).
//     4. Otherwise PC = ProgCtr + 1.
//     RomAddr is the next PC, combinational, so there is no bubble after a taken jump.
//   - HALT:  InstrValid=0, Instruction=kNOP, Done=1, ProgCtr frozen.
//     Start=1 -> PRIME; Done drops in the PRIME cycle.
// - Start is ignored in PRIME and RUN. Start held high at HALT re-enters PRIME at once.
// - PC arithmetic is modulo 2**PC_W: 2**PC_W-1 + 1 -> 0, and 0 + (-1) -> 2**PC_W-1.
//   No error flag.
// - Jump/AckIn/Stall are sampled only in RUN; they are don't-care in other states.
// - A Stall held across many cycles must leave Instruction and ProgCtr bit-stable.
// CONFIGURATION
// - FETCH_PERF_EN defined:
//   - CycleCount increments every RUN cycle.
//   - InstrCount increments on each RUN cycle with Stall=0; the halt instruction counts.
//   - Both clear in PRIME, saturate at all-ones, and hold in HALT.
// - FETCH_PERF_EN undefined: both ports are constant 0; no counter flops are synthesized.
// STRUCTURE
// - defs_pkg (shared) holds:
//   - kINSTR_W=9
//   - kNOP: the all-zero 9-bit word
//   - kHALT=9'h1FF
//   - fetch_state_t enum {IDLE,PRIME,RUN,HALT}
// - Sub-module pc_next_calc: combinational priority mux + modulo adder;
//   produces next PC and RomAddr.
// - FSM, registers and perf counters live in fetch_sequencer.
// TESTING
// - Reset then Start pulse, ROM[0..3]=A,B,C,kHALT, AckIn driven on kHALT:
//   Instruction A,B,C,kHALT on consecutive cycles starting 2 cycles after Start;
//   Done=1 next cycle; ProgCtr stays 3.
// - Jump at PC=5 with JumpOff=8'hFD: next ProgCtr=2, InstrValid unbroken (no bubble).
//   Jump at PC=1023 with JumpOff=+1: next ProgCtr=0.
// - Stall=1 for 3 cycles at PC=7 with Jump=1 and AckIn=0: ProgCtr=7 and Instruction
//   unchanged for 3 cycles. On the first cycle after Stall drops, the jump target is taken.
// - AckIn and Stall and Jump together at PC=9: HALT entered, ProgCtr=9, Done=1.
//   Then Start=1: PRIME, Done=0, ProgCtr=0, ROM[0] presented 2 cycles later.
// - Reset asserted mid-RUN at PC=20, off the clock edge: all outputs reach reset values
//   without a clock edge. Start ignored while RUN (ProgCtr sequence unaffected).
// - FETCH_PERF_EN: a 10-instruction program with 2 stall cycles gives CycleCount=12 and
//   InstrCount=10. Without the macro both read 0.

Source files
------------

// File: rtl/defs_pkg.sv
// Shared definitions for the 9-bit machine-code path: instruction width,
// reserved words and the fetch FSM state type.
package defs_pkg;

  localparam int kINSTR_W = 9;

  localparam logic [kINSTR_W-1:0] kNOP  = '0;
  localparam logic [kINSTR_W-1:0] kHALT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch sequencer: priority mux (halt, stall, jump,
// increment) with modulo-2**PC_W arithmetic, plus the ROM read address.
module pc_next_calc
  import defs_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  fetch_state_t      state,
  input  logic              start,
  input  logic              ack,
  input  logic              stall,
  input  logic              jump,
  input  logic [OFF_W-1:0]  jump_off,
  input  logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   next_pc,
  output logic [PC_W-1:0]   rom_addr
);

  logic [PC_W-1:0] off_ext;

  // The signed cast makes the size cast sign-extend; overflow wraps naturally.
  assign off_ext = PC_W'($signed(jump_off));

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    next_pc  = pc;
    rom_addr = '0;
    unique case (state)
      IDLE, HALT: begin
        if (start) next_pc = '0;
      end
      PRIME: next_pc = '0;
      RUN: begin
        if (ack)        next_pc = pc;
        else if (stall) next_pc = pc;
        else if (jump)  next_pc = pc + off_ext;
        else            next_pc = pc + PC_W'(1);
        rom_addr = next_pc;
      end
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the sync ROM and runs the
// Start/Done handshake. Optional perf counters are built with FETCH_PERF_EN.
module fetch_sequencer
  import defs_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = kINSTR_W,
  parameter int OFF_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Jump,
  input  logic [OFF_W-1:0]   JumpOff,
  input  logic               AckIn,
  input  logic [INSTR_W-1:0] RomData,
  output logic [PC_W-1:0]    RomAddr,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic [PC_W-1:0]    ProgCtr,
  output logic               Done,
  output logic [CNT_W-1:0]   CycleCount,
  output logic [CNT_W-1:0]   InstrCount
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  pc_next_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next_calc (
    .state    (state_q),
    .start    (Start),
    .ack      (AckIn),
    .stall    (Stall),
    .jump     (Jump),
    .jump_off (JumpOff),
    .pc       (pc_q),
    .next_pc  (pc_d),
    .rom_addr (RomAddr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = PRIME;
      PRIME:   state_d = RUN;
      RUN:     if (AckIn) state_d = HALT;
      HALT:    if (Start) state_d = PRIME;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign InstrValid  = (state_q == RUN);
  assign Instruction = InstrValid ? RomData : kNOP;
  assign Done        = (state_q == HALT);
  assign ProgCtr     = pc_q;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (state_q == PRIME) begin
      cycle_d = '0;
      instr_d = '0;
    end else if (state_q == RUN) begin
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if ((!Stall || AckIn) && instr_q != '1) instr_d = instr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign CycleCount = cycle_q;
  assign InstrCount = instr_q;
`else
  assign CycleCount = '0;
  assign InstrCount = '0;
`endif

endmodule
